// File: rtl/cc_muxx_bus_arb.sv
// cc_muxx_bus_arb: registered N-channel bus multiplexer with fixed-select or
// round-robin arbitration. The output word is held under a valid/ready
// handshake, and a one-cycle registered grant marks each accepted source word.
// Optional build macro: CC_MUXX_BUS_ARB_PARITY_EN adds a registered even-parity
// bit that tracks data_OutBUS.
module cc_muxx_bus_arb #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int DATAWIDTH_SEL = 2
) (
  input  logic                                    CC_MUXX_BUS_ARB_CLOCK_50,
  input  logic                                    CC_MUXX_BUS_ARB_RESET_InLow,
  input  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0]   CC_MUXX_BUS_ARB_data_InBUS,
  input  logic [NUM_CHANNELS-1:0]                 CC_MUXX_BUS_ARB_request_InBUS,
  input  logic                                    CC_MUXX_BUS_ARB_mode_InBUS,
  input  logic [DATAWIDTH_SEL-1:0]                CC_MUXX_BUS_ARB_selector_InBUS,
  input  logic                                    CC_MUXX_BUS_ARB_ready_InBUS,
  output logic [DATAWIDTH_BUS-1:0]                CC_MUXX_BUS_ARB_data_OutBUS,
  output logic                                    CC_MUXX_BUS_ARB_valid_Out,
  output logic [NUM_CHANNELS-1:0]                 CC_MUXX_BUS_ARB_grant_Out
`ifdef CC_MUXX_BUS_ARB_PARITY_EN
  ,
  output logic                                    CC_MUXX_BUS_ARB_parity_Out
`endif
);

  localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic {IDLE, BUSY} stateT;

  stateT                    stateReg, stateNext;
  logic [PTR_W-1:0]         rrPtrReg, rrPtrNext;
  logic [DATAWIDTH_BUS-1:0] dataReg, dataNext;
  logic                     validReg, validNext;
  logic [NUM_CHANNELS-1:0]  grantReg, grantNext;

  logic [DATAWIDTH_BUS-1:0] chanData [NUM_CHANNELS];
  logic                     fixFound, rrFound, winFound, canLoad;
  logic [PTR_W-1:0]         fixWin, rrWin, winIdx;

  // Unflatten the channel bus into an indexable array.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : genChan
      assign chanData[gi] = CC_MUXX_BUS_ARB_data_InBUS[gi*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end
  endgenerate

  // Fixed mode: the selected channel wins only if it exists and is requesting.
  always_comb begin
    fixFound = 1'b0;
    fixWin   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if ((CC_MUXX_BUS_ARB_selector_InBUS == DATAWIDTH_SEL'(i)) &&
          CC_MUXX_BUS_ARB_request_InBUS[i]) begin
        fixFound = 1'b1;
        fixWin   = PTR_W'(i);
      end
    end
  end

  // Round-robin: first requester found scanning upward from the pointer.
  always_comb begin
    int idx;
    idx     = 0;
    rrFound = 1'b0;
    rrWin   = '0;
    for (int off = 0; off < NUM_CHANNELS; off++) begin
      idx = (int'(rrPtrReg) + off) % NUM_CHANNELS;
      if (!rrFound && CC_MUXX_BUS_ARB_request_InBUS[idx]) begin
        rrFound = 1'b1;
        rrWin   = PTR_W'(idx);
      end
    end
  end

  // Next-state and output logic; mode only matters at a load point.
  always_comb begin
    stateNext = stateReg;
    rrPtrNext = rrPtrReg;
    dataNext  = dataReg;
    validNext = validReg;
    grantNext = '0;
    winFound  = CC_MUXX_BUS_ARB_mode_InBUS ? rrFound : fixFound;
    winIdx    = CC_MUXX_BUS_ARB_mode_InBUS ? rrWin : fixWin;
    canLoad   = (stateReg == IDLE) || CC_MUXX_BUS_ARB_ready_InBUS;
    if (canLoad) begin
      if (winFound) begin
        dataNext          = chanData[winIdx];
        validNext         = 1'b1;
        grantNext[winIdx] = 1'b1;
        stateNext         = BUSY;
        if (CC_MUXX_BUS_ARB_mode_InBUS) begin
          rrPtrNext = PTR_W'((int'(winIdx) + 1) % NUM_CHANNELS);
        end
      end else begin
        // Word consumed (or nothing pending) and no new source: drop valid,
        // leave the last data on the bus.
        validNext = 1'b0;
        stateNext = IDLE;
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CC_MUXX_BUS_ARB_CLOCK_50 or negedge CC_MUXX_BUS_ARB_RESET_InLow) begin
    if (!CC_MUXX_BUS_ARB_RESET_InLow) begin
      stateReg <= IDLE;
      rrPtrReg <= '0;
      dataReg  <= '0;
      validReg <= 1'b0;
      grantReg <= '0;
    end else begin
      stateReg <= stateNext;
      rrPtrReg <= rrPtrNext;
      dataReg  <= dataNext;
      validReg <= validNext;
      grantReg <= grantNext;
    end
  end

  assign CC_MUXX_BUS_ARB_data_OutBUS = dataReg;
  assign CC_MUXX_BUS_ARB_valid_Out   = validReg;
  assign CC_MUXX_BUS_ARB_grant_Out   = grantReg;

`ifdef CC_MUXX_BUS_ARB_PARITY_EN
  logic parityReg;

  // Parity follows dataNext, so it changes on loads and holds with the data.
  always_ff @(posedge CC_MUXX_BUS_ARB_CLOCK_50 or negedge CC_MUXX_BUS_ARB_RESET_InLow) begin
    if (!CC_MUXX_BUS_ARB_RESET_InLow) begin
      parityReg <= 1'b0;
    end else begin
      parityReg <= ^dataNext;
    end
  end

  assign CC_MUXX_BUS_ARB_parity_Out = parityReg;
`endif

endmodule

// File: tb/tb_cc_muxx_bus_arb.sv
// Directed testbench for cc_muxx_bus_arb: a 4-channel instance for the main
// behaviour and a 3-channel instance for the out-of-range selector case.
module tb_cc_muxx_bus_arb;

  logic        clk = 1'b0;
  logic        rstN;

  // 4-channel instance
  logic [31:0] dataBus;
  logic [3:0]  req;
  logic        mode;
  logic [1:0]  sel;
  logic        ready;
  logic [7:0]  dataOut;
  logic        validOut;
  logic [3:0]  grantOut;

  // 3-channel instance
  logic [23:0] dataBus3;
  logic [2:0]  req3;
  logic        mode3;
  logic [1:0]  sel3;
  logic        ready3;
  logic [7:0]  dataOut3;
  logic        validOut3;
  logic [2:0]  grantOut3;

`ifdef CC_MUXX_BUS_ARB_PARITY_EN
  logic        parityOut;
  logic        parityOut3;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  cc_muxx_bus_arb #(.DATAWIDTH_BUS(8), .NUM_CHANNELS(4), .DATAWIDTH_SEL(2)) dut (
    .CC_MUXX_BUS_ARB_CLOCK_50       (clk),
    .CC_MUXX_BUS_ARB_RESET_InLow    (rstN),
    .CC_MUXX_BUS_ARB_data_InBUS     (dataBus),
    .CC_MUXX_BUS_ARB_request_InBUS  (req),
    .CC_MUXX_BUS_ARB_mode_InBUS     (mode),
    .CC_MUXX_BUS_ARB_selector_InBUS (sel),
    .CC_MUXX_BUS_ARB_ready_InBUS    (ready),
    .CC_MUXX_BUS_ARB_data_OutBUS    (dataOut),
    .CC_MUXX_BUS_ARB_valid_Out      (validOut),
    .CC_MUXX_BUS_ARB_grant_Out      (grantOut)
`ifdef CC_MUXX_BUS_ARB_PARITY_EN
    ,
    .CC_MUXX_BUS_ARB_parity_Out     (parityOut)
`endif
  );

  cc_muxx_bus_arb #(.DATAWIDTH_BUS(8), .NUM_CHANNELS(3), .DATAWIDTH_SEL(2)) dut3 (
    .CC_MUXX_BUS_ARB_CLOCK_50       (clk),
    .CC_MUXX_BUS_ARB_RESET_InLow    (rstN),
    .CC_MUXX_BUS_ARB_data_InBUS     (dataBus3),
    .CC_MUXX_BUS_ARB_request_InBUS  (req3),
    .CC_MUXX_BUS_ARB_mode_InBUS     (mode3),
    .CC_MUXX_BUS_ARB_selector_InBUS (sel3),
    .CC_MUXX_BUS_ARB_ready_InBUS    (ready3),
    .CC_MUXX_BUS_ARB_data_OutBUS    (dataOut3),
    .CC_MUXX_BUS_ARB_valid_Out      (validOut3),
    .CC_MUXX_BUS_ARB_grant_Out      (grantOut3)
`ifdef CC_MUXX_BUS_ARB_PARITY_EN
    ,
    .CC_MUXX_BUS_ARB_parity_Out     (parityOut3)
`endif
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    nCompared++;
    if (obs !== expVal) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expVal);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic [7:0] d, input logic v, input logic [3:0] g);
    checkEq({tag, ".data"},  {24'h0, dataOut},  {24'h0, d});
    checkEq({tag, ".valid"}, {31'h0, validOut}, {31'h0, v});
    checkEq({tag, ".grant"}, {28'h0, grantOut}, {28'h0, g});
  endtask

  initial begin
    rstN     = 1'b0;
    dataBus  = '0; req  = '0; mode  = 1'b0; sel  = '0; ready  = 1'b0;
    dataBus3 = '0; req3 = '0; mode3 = 1'b0; sel3 = '0; ready3 = 1'b0;
    tick();
    tick();
    checkOut("reset", 8'h00, 1'b0, 4'b0000);
    rstN = 1'b1;

    // Fixed mode, sel = 2
    mode = 1'b0; sel = 2'd2; req = 4'b0100; ready = 1'b1;
    dataBus = {8'h44, 8'hA5, 8'h22, 8'h11};
    tick();
    checkOut("fix_load", 8'hA5, 1'b1, 4'b0100);
    req = 4'b0000;
    tick();
    checkOut("fix_drop", 8'hA5, 1'b0, 4'b0000);

    // Round-robin with all requesting; pointer still 0
    mode = 1'b1; req = 4'b1111;
    dataBus = {8'h44, 8'h33, 8'h22, 8'h11};
    tick(); checkOut("rr0", 8'h11, 1'b1, 4'b0001);
    tick(); checkOut("rr1", 8'h22, 1'b1, 4'b0010);
    tick(); checkOut("rr2", 8'h33, 1'b1, 4'b0100);
    tick(); checkOut("rr3", 8'h44, 1'b1, 4'b1000);
    tick(); checkOut("rr4", 8'h11, 1'b1, 4'b0001);
    req = 4'b0000;
    tick(); checkOut("rr_idle", 8'h11, 1'b0, 4'b0000);

    // Backpressure: pointer is 1, ch1 wins
    req = 4'b0010; dataBus = {8'h44, 8'h33, 8'h3C, 8'h11};
    tick(); checkOut("bp_load", 8'h3C, 1'b1, 4'b0010);
    ready = 1'b0; dataBus = {8'h44, 8'h33, 8'h77, 8'h11};
    mode = 1'b0; sel = 2'd3;  // ignored while stalled
    for (int i = 0; i < 3; i++) begin
      tick(); checkOut($sformatf("bp_hold%0d", i), 8'h3C, 1'b1, 4'b0000);
    end
    mode = 1'b1; ready = 1'b1;
    tick(); checkOut("bp_release", 8'h77, 1'b1, 4'b0010);
    req = 4'b0000;
    tick(); checkOut("bp_idle", 8'h77, 1'b0, 4'b0000);

    // Async reset mid-transfer; pointer is 2 before this, 1 after ch0 grant
    req = 4'b0001; ready = 1'b0; dataBus = {8'h44, 8'h33, 8'h22, 8'h5A};
    tick(); checkOut("pre_rst", 8'h5A, 1'b1, 4'b0001);
    tick(); checkOut("pre_rst_hold", 8'h5A, 1'b1, 4'b0000);
    rstN = 1'b0;
    #1;
    checkOut("async_rst", 8'h00, 1'b0, 4'b0000);
    @(negedge clk);
    rstN = 1'b1;
    req = 4'b1111; ready = 1'b1; dataBus = {8'h44, 8'h33, 8'h22, 8'h11};
    tick(); checkOut("post_rst", 8'h11, 1'b1, 4'b0001);
    req = 4'b0000;
    tick(); checkOut("post_rst_idle", 8'h11, 1'b0, 4'b0000);

    // 3-channel instance: sel = 3 is out of range
    mode3 = 1'b0; sel3 = 2'd3; req3 = 3'b111; ready3 = 1'b1;
    dataBus3 = {8'hC3, 8'hB2, 8'hA1};
    tick();
    checkEq("oor.valid", {31'h0, validOut3}, 32'h0);
    checkEq("oor.grant", {29'h0, grantOut3}, 32'h0);
    tick();
    checkEq("oor.valid2", {31'h0, validOut3}, 32'h0);
    checkEq("oor.data",   {24'h0, dataOut3},  32'h0);
    sel3 = 2'd2;
    tick();
    checkEq("n3_sel2.valid", {31'h0, validOut3}, 32'h1);
    checkEq("n3_sel2.grant", {29'h0, grantOut3}, 32'h4);
    checkEq("n3_sel2.data",  {24'h0, dataOut3},  32'hC3);

`ifdef CC_MUXX_BUS_ARB_PARITY_EN
    // Parity: 0x07 has odd weight, 0x03 even
    mode = 1'b0; sel = 2'd0; req = 4'b0001; ready = 1'b1;
    dataBus = {8'h00, 8'h00, 8'h03, 8'h07};
    tick();
    checkEq("par07.data", {24'h0, dataOut}, 32'h07);
    checkEq("par07", {31'h0, parityOut}, 32'h1);
    sel = 2'd1; req = 4'b0010;
    tick();
    checkEq("par03.data", {24'h0, dataOut}, 32'h03);
    checkEq("par03", {31'h0, parityOut}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cc_muxx_bus_arb.md
# cc_muxx_bus_arb

Parametrised, registered N-channel bus multiplexer with request/grant arbitration. It drives the datapath bus from one of NUM_CHANNELS sources: register-file ports, control constants or peripherals. Two modes are supported: fixed selection, where a control code picks the source, and round-robin arbitration among requesting sources. The output is held stable under a valid/ready handshake toward the bus consumer (ALU/register write port).

## Interface
- DATAWIDTH_BUS, 8: width of each channel and of the output bus.
- NUM_CHANNELS, 4: number of source channels (2..16).
- DATAWIDTH_SEL, 2: width of the select code; must be ≥ ceil(log2(NUM_CHANNELS)).
- CC_MUXX_BUS_ARB_CLOCK_50  in  1: system clock, all state on rising edge.
- CC_MUXX_BUS_ARB_RESET_InLow  in  1: asynchronous, active-low reset.
- CC_MUXX_BUS_ARB_data_InBUS  in  NUM_CHANNELS*DATAWIDTH_BUS: flattened channel data; channel i occupies bits [i*DATAWIDTH_BUS +: DATAWIDTH_BUS].
- CC_MUXX_BUS_ARB_request_InBUS  in  NUM_CHANNELS: per-channel request, level.
- CC_MUXX_BUS_ARB_mode_InBUS  in  1: 0 = fixed select, 1 = round-robin.
- CC_MUXX_BUS_ARB_selector_InBUS  in  DATAWIDTH_SEL: channel index used in fixed mode.
- CC_MUXX_BUS_ARB_ready_InBUS  in  1: consumer accepts the output this cycle.
- CC_MUXX_BUS_ARB_data_OutBUS  out  DATAWIDTH_BUS: registered bus data.
- CC_MUXX_BUS_ARB_valid_Out  out  1: data_OutBUS holds an unconsumed word.
- CC_MUXX_BUS_ARB_grant_Out  out  NUM_CHANNELS: registered one-hot grant, one-cycle pulse per accepted word.
- CC_MUXX_BUS_ARB_parity_Out  out  1: present only with CC_MUXX_BUS_ARB_PARITY_EN.

## Operation
- Reset values: data_OutBUS = 0, valid_Out = 0, grant_Out = 0, parity_Out = 0, state = IDLE, round-robin pointer = 0.
- Eligibility:
  - Fixed mode: only channel sel, and only if sel < NUM_CHANNELS and request[sel] = 1.
  - Round-robin mode: first requesting channel found searching upward from the pointer, modulo NUM_CHANNELS.
- The load condition ("can load") is: state IDLE, or state BUSY with ready = 1.
- FSM IDLE:
  - Eligible channel w exists → register data[w], valid = 1, grant = onehot(w), go to BUSY.
  - Otherwise remain in IDLE, grant = 0.
- FSM BUSY:
  - ready = 0 → hold data, hold valid, grant = 0. Requests are ignored and the pointer does not move.
  - ready = 1 with an eligible w → back-to-back load: new data, valid stays 1, grant = onehot(w), stay in BUSY.
  - ready = 1 with no eligible channel → valid = 0, grant = 0, go to IDLE. data_OutBUS keeps its last value.
- Pointer update: on each grant in round-robin mode, pointer = (w+1) mod NUM_CHANNELS. Fixed-mode grants leave the pointer unchanged.
- Sources hold data and request until they see their grant bit. A source that keeps its request asserted after a grant is treated as requesting another transfer.
- Mode and selector are sampled only at load points. A change while BUSY with ready = 0 has no effect until the next load.
- Out-of-range selector in fixed mode → never eligible. No grant is issued and valid falls after the current word is consumed.

## Timing
- Latency: request sampled at edge k → data_OutBUS, valid_Out and grant_Out update after edge k (1 cycle).
- Throughput: one word per cycle while ready = 1 and an eligible request is present.
- Grant is registered and aligned with the cycle in which the new data first appears.
- Async reset during BUSY clears all outputs immediately, with no clock needed. The in-flight word is discarded.
- Reset release: the first load can occur on the first rising edge after the reset deassertion.

## Configuration
- CC_MUXX_BUS_ARB_PARITY_EN defined:
  - parity_Out is a registered even-parity bit (XOR of all bits of data_OutBUS).
  - It updates on every load and holds with the data.
  - It resets to 0.
- Undefined: the parity_Out port and its logic are absent.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert RESET_InLow = 0 mid-transfer with valid = 1 → data_OutBUS = 0x00, valid = 0, grant = 0000 immediately. The first grant after release goes to channel 0 in round-robin.
- Fixed mode, sel = 2, request = 0100, data ch2 = 0xA5, ready = 1 → next cycle data_OutBUS = 0xA5, valid = 1, grant = 0100. With request dropped, valid returns to 0 the following cycle.
- Round-robin, request = 1111 held, ready = 1 → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with valid continuously 1.
- Backpressure: valid = 1 with ch1 = 0x3C, ready = 0 for 3 cycles while ch1 changes to 0x77 → data_OutBUS stays 0x3C and grant stays 0000. ready = 1 then loads the next eligible word.
- Fixed mode, sel = 3 with NUM_CHANNELS = 3 and all requests asserted → no grant and valid stays 0.
- Parity build: ch0 = 0x07 granted → parity_Out = 1. Then ch1 = 0x03 granted → parity_Out = 0.
